// File: rtl/prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: memory fetch port, flush/redirect
// port and the byte-wide decoder handshake.
interface prefetch_queue_if;
  logic        mem_grant;
  logic        mem_req;
  logic [19:0] mem_address;
  logic [7:0]  mem_data;
  logic        flush;
  logic [15:0] new_cs;
  logic [15:0] new_ip;
  logic [7:0]  q_data;
  logic        q_valid;
  logic        q_take;
  logic [15:0] q_ip;
  logic [3:0]  q_count;

  modport master (
    input  mem_grant, mem_data, flush, new_cs, new_ip, q_take,
    output mem_req, mem_address, q_data, q_valid, q_ip, q_count
  );

  modport slave (
    output mem_grant, mem_data, flush, new_cs, new_ip, q_take,
    input  mem_req, mem_address, q_data, q_valid, q_ip, q_count
  );
endinterface

// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch queue: fetches code bytes at CS:IP while the bus is
// idle and hands them to the decoder in order, restarting on any control transfer.
module prefetch_queue #(
  parameter int          DEPTH    = 6,
  parameter logic [15:0] RESET_CS = 16'hFFFF,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input logic              clock,
  input logic              reset_n,
  prefetch_queue_if.master bus
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {LOAD, FETCH, FULL} state_t;

  state_t           state, state_nxt;
  logic [15:0]      fcs, fip, hip;
  logic [PTR_W-1:0] rd, wr;
  logic [CNT_W-1:0] count;
  logic [7:0]       store [DEPTH];
  logic             not_empty;
  logic             do_fetch;
  logic             do_take;

  function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // q_count is four bits wide, so a full 16-deep queue reports 15.
  function automatic logic [3:0] count_sat(input logic [CNT_W-1:0] c);
    return (32'(c) > 32'd15) ? 4'hF : 4'(c);
  endfunction

  assign not_empty = (count != '0);
  assign do_fetch  = (state == FETCH) && bus.mem_grant && !bus.flush;
  assign do_take   = bus.q_take && not_empty && !bus.flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.mem_req = 1'b0;
    unique case (state)
      LOAD:  state_nxt = FETCH;
      FETCH: begin
        bus.mem_req = 1'b1;
        if (do_fetch && !do_take && (count == FULL_CNT - ONE_CNT)) state_nxt = FULL;
      end
      FULL:  if (do_take) state_nxt = FETCH;
      default: state_nxt = LOAD;
    endcase
    if (bus.flush) state_nxt = LOAD;
  end

  // Control and pointer state; flush overrides any fetch or take in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      rd    <= '0;
      wr    <= '0;
      fcs   <= RESET_CS;
      fip   <= RESET_IP;
      hip   <= RESET_IP;
    end else if (bus.flush) begin
      count <= '0;
      rd    <= '0;
      wr    <= '0;
      fcs   <= bus.new_cs;
      fip   <= bus.new_ip;
      hip   <= bus.new_ip;
    end else begin
      if (do_fetch) begin
        wr  <= ptr_inc(wr);
        fip <= fip + 16'd1;
      end
      if (do_take) begin
        rd  <= ptr_inc(rd);
        hip <= hip + 16'd1;
      end
      unique case ({do_fetch, do_take})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Byte storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_fetch) store[wr] <= bus.mem_data;
  end

  assign bus.q_valid     = not_empty;
  assign bus.q_data      = not_empty ? store[rd] : 8'h00;
  assign bus.q_ip        = hip;
  assign bus.q_count     = count_sat(count);
  assign bus.mem_address = phys_addr(fcs, fip);

  a_count_range: assert property (@(posedge clock) disable iff (!reset_n)
    count <= FULL_CNT);
  a_full_state: assert property (@(posedge clock) disable iff (!reset_n)
    (state == FULL) == (count == FULL_CNT));
  a_load_empty: assert property (@(posedge clock) disable iff (!reset_n)
    (state == LOAD) |-> (count == '0));

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_prefetch_queue;
  localparam int DEPTH = 6;

  logic clock;
  logic reset_n;
  prefetch_queue_if ifc ();

  prefetch_queue #(.DEPTH(DEPTH), .RESET_CS(16'hFFFF), .RESET_IP(16'h0000)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    case (a)
      20'hFFFF0: return 8'hEA;
      20'hFFFF1: return 8'h00;
      20'hFFFF2: return 8'h01;
      20'hFFFF3: return 8'h00;
      20'hFFFF4: return 8'hF0;
      20'hFFFF5: return 8'h90;
      default:   return a[7:0] ^ {a[19:16], a[11:8]};
    endcase
  endfunction

  assign ifc.mem_data = mem_byte(ifc.mem_address);

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  logic [7:0]  mq[$];
  logic [15:0] mfcs, mfip, mhip;
  bit          mload;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [19:0] model_addr();
    int unsigned a;
    a = (int'(mfcs) * 16 + int'(mfip)) % (1 << 20);
    return 20'(a);
  endfunction

  task automatic model_reset();
    mq.delete();
    mfcs  = 16'hFFFF;
    mfip  = 16'h0000;
    mhip  = 16'h0000;
    mload = 1'b1;
  endtask

  task automatic model_edge();
    bit fetch, take;
    if (ifc.flush) begin
      mq.delete();
      mfcs  = ifc.new_cs;
      mfip  = ifc.new_ip;
      mhip  = ifc.new_ip;
      mload = 1'b1;
      return;
    end
    fetch = !mload && (mq.size() < DEPTH) && ifc.mem_grant;
    take  = ifc.q_take && (mq.size() != 0);
    if (take) begin
      void'(mq.pop_front());
      mhip = mhip + 16'd1;
    end
    if (fetch) begin
      mq.push_back(mem_byte(model_addr()));
      mfip = mfip + 16'd1;
    end
    mload = 1'b0;
  endtask

  task automatic compare_all();
    chk("q_valid", 32'(ifc.q_valid), 32'(mq.size() != 0));
    chk("q_data", 32'(ifc.q_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("q_ip", 32'(ifc.q_ip), 32'(mhip));
    chk("q_count", 32'(ifc.q_count), 32'(mq.size()));
    chk("mem_req", 32'(ifc.mem_req), 32'(!mload && (mq.size() < DEPTH)));
    chk("mem_address", 32'(ifc.mem_address), 32'(model_addr()));
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) compare_all();
    end
  end

  task automatic cyc(input bit g, input bit t, input bit f = 1'b0,
                     input logic [15:0] cs = 16'h0, input logic [15:0] ip = 16'h0);
    ifc.mem_grant = g;
    ifc.q_take    = t;
    ifc.flush     = f;
    ifc.new_cs    = cs;
    ifc.new_ip    = ip;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_q_count"}, 32'(ifc.q_count), 32'd0);
    chk({tag, "_q_valid"}, 32'(ifc.q_valid), 32'd0);
    chk({tag, "_q_data"}, 32'(ifc.q_data), 32'd0);
    chk({tag, "_mem_req"}, 32'(ifc.mem_req), 32'd0);
    chk({tag, "_mem_address"}, 32'(ifc.mem_address), 32'h000FFFF0);
    chk({tag, "_q_ip"}, 32'(ifc.q_ip), 32'h0000);
  endtask

  initial begin
    reset_n       = 1'b0;
    ifc.mem_grant = 1'b0;
    ifc.q_take    = 1'b0;
    ifc.flush     = 1'b0;
    ifc.new_cs    = 16'h0;
    ifc.new_ip    = 16'h0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_literals("reset");
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Power-up fill from FFFF:0000 until full.
    cyc(1, 0);
    chk("load_q_count", 32'(ifc.q_count), 32'd0);
    chk("load_then_req", 32'(ifc.mem_req), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1, 0);
    chk("fill_q_count", 32'(ifc.q_count), 32'd6);
    chk("fill_mem_req", 32'(ifc.mem_req), 32'd0);
    chk("fill_q_data", 32'(ifc.q_data), 32'hEA);
    chk("fill_q_ip", 32'(ifc.q_ip), 32'h0000);
    cyc(1, 0);
    chk("full_blocked_count", 32'(ifc.q_count), 32'd6);

    // One take from full, then refill from FFFF6.
    cyc(1, 1);
    chk("take_q_data", 32'(ifc.q_data), 32'h00);
    chk("take_q_ip", 32'(ifc.q_ip), 32'h0001);
    chk("take_q_count", 32'(ifc.q_count), 32'd5);
    chk("refill_addr", 32'(ifc.mem_address), 32'h000FFFF6);
    cyc(1, 0);
    chk("refill_count", 32'(ifc.q_count), 32'd6);
    chk("refill_next_addr", 32'(ifc.mem_address), 32'h000FFFF7);

    // Drain, then alternate grant with take held.
    for (int i = 0; i < 6; i++) cyc(0, 1);
    chk("drain_q_valid", 32'(ifc.q_valid), 32'd0);
    chk("drain_q_ip", 32'(ifc.q_ip), 32'h0007);
    for (int i = 0; i < 4; i++) begin
      cyc(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
      chk("toggle_count", 32'(ifc.q_count), ((i % 2) == 0) ? 32'd1 : 32'd0);
    end
    chk("toggle_q_ip", 32'(ifc.q_ip), 32'h0009);

    // Flush with take and grant active in the same cycle.
    for (int i = 0; i < 4; i++) cyc(1, 0);
    chk("pre_flush_count", 32'(ifc.q_count), 32'd4);
    cyc(1, 1, 1'b1, 16'h1234, 16'h0010);
    chk("flush_count", 32'(ifc.q_count), 32'd0);
    chk("flush_q_valid", 32'(ifc.q_valid), 32'd0);
    chk("flush_q_ip", 32'(ifc.q_ip), 32'h0010);
    chk("flush_mem_req", 32'(ifc.mem_req), 32'd0);
    cyc(0, 0);
    chk("flush_addr", 32'(ifc.mem_address), 32'h00012350);
    chk("flush_load_req", 32'(ifc.mem_req), 32'd1);

    // IP wraparound within segment 2000.
    cyc(0, 0, 1'b1, 16'h2000, 16'hFFFE);
    cyc(0, 0);
    chk("wrap_addr0", 32'(ifc.mem_address), 32'h0002FFFE);
    cyc(1, 0);
    chk("wrap_addr1", 32'(ifc.mem_address), 32'h0002FFFF);
    cyc(1, 0);
    chk("wrap_addr2", 32'(ifc.mem_address), 32'h00020000);
    cyc(1, 0);
    chk("wrap_ip0", 32'(ifc.q_ip), 32'hFFFE);
    cyc(0, 1);
    chk("wrap_ip1", 32'(ifc.q_ip), 32'hFFFF);
    cyc(0, 1);
    chk("wrap_ip2", 32'(ifc.q_ip), 32'h0000);

    // Physical address carry out of bit 19 is dropped.
    cyc(0, 0, 1'b1, 16'hFFFF, 16'h0010);
    chk("carry_addr", 32'(ifc.mem_address), 32'h00000000);
    cyc(0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0);
    chk("pre_reset_count", 32'(ifc.q_count), 32'd3);

    // Asynchronous reset mid-cycle with a fetch in flight.
    ifc.mem_grant = 1'b1;
    #2;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    reset_literals("async");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    cyc(1, 0);
    chk("restart_addr", 32'(ifc.mem_address), 32'h000FFFF0);
    chk("restart_req", 32'(ifc.mem_req), 32'd1);
    cyc(1, 0);
    chk("restart_q_data", 32'(ifc.q_data), 32'hEA);
    chk("restart_count", 32'(ifc.q_count), 32'd1);
    cyc(0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
